psum_acc_reader: RTL and testbench

- Hardware sequencer that reads partial sums back out of the psum memory (PMEM) after all kij passes have been written.
- Drives the SFU accumulate/clear controls and hands each finished output-pixel vector downstream over a valid/ready port.
- It is the reader counterpart to the OFIFO-to-PMEM writer path.
- Replaces the bench-driven accumulation loop, so the core can run convolution end to end without the bench computing addresses.

---
 rtl/psum_acc_reader_pkg.sv | 45 ++++
 rtl/psum_acc_reader_if.sv | 24 ++
 rtl/psum_addr_gen.sv | 79 +++++++
 rtl/psum_acc_reader.sv | 120 ++++++++++++
 tb/tb_psum_acc_reader.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/psum_acc_reader_pkg.sv
// Shared geometry, PMEM control polarity and FSM encoding for the psum
// accumulation reader and its address generator.
package psum_acc_reader_pkg;

  localparam int COL          = 8;
  localparam int PSUM_BW      = 16;
  localparam int ADDR_BW      = 11;
  localparam int A_PAD_NI_DIM = 6;
  localparam int O_NI_DIM     = 4;
  localparam int KI_DIM       = 3;
  localparam int LEN_NIJ      = A_PAD_NI_DIM * A_PAD_NI_DIM;
  localparam int LEN_ONIJ     = O_NI_DIM * O_NI_DIM;
  localparam int LEN_KIJ      = KI_DIM * KI_DIM;
  localparam int VEC_BW       = COL * PSUM_BW;

  localparam logic CEN_ON   = 1'b0;
  localparam logic CEN_OFF  = 1'b1;
  localparam logic WEN_READ = 1'b1;

  typedef logic [ADDR_BW-1:0]               addr_t;
  typedef logic [VEC_BW-1:0]                vec_t;
  typedef logic [$clog2(LEN_ONIJ)-1:0]      pix_t;
  typedef logic [$clog2(LEN_KIJ+1)-1:0]     rd_cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RD,
    ST_SETTLE,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam pix_t    O_LAST     = pix_t'(LEN_ONIJ - 1);
  localparam pix_t    O_COL_LAST = pix_t'(O_NI_DIM - 1);
  localparam pix_t    J_COL_LAST = pix_t'(KI_DIM - 1);
  localparam rd_cnt_t RD_LAST    = rd_cnt_t'(LEN_KIJ);

  // Address increments: stepping a column vs. wrapping to the next row.
  localparam addr_t O_COL_STEP = addr_t'(1);
  localparam addr_t O_ROW_STEP = addr_t'(A_PAD_NI_DIM - (O_NI_DIM - 1));
  localparam addr_t J_COL_STEP = addr_t'(1 + LEN_NIJ);
  localparam addr_t J_ROW_STEP = addr_t'(A_PAD_NI_DIM - (KI_DIM - 1) + LEN_NIJ);

endpackage

// File: rtl/psum_acc_reader_if.sv
// PMEM read port, SFU control/data and the downstream valid/ready port.
interface psum_acc_reader_if
  import psum_acc_reader_pkg::*;
;
  logic  pmem_cen;
  logic  pmem_wen;
  addr_t pmem_addr;
  logic  sfu_clr;
  logic  acc;
  vec_t  sfu_out;
  logic  out_valid;
  logic  out_ready;
  vec_t  out_data;

  modport master (
    output pmem_cen, pmem_wen, pmem_addr, sfu_clr, acc, out_valid, out_data,
    input  sfu_out, out_ready
  );

  modport slave (
    input  pmem_cen, pmem_wen, pmem_addr, sfu_clr, acc, out_valid, out_data,
    output sfu_out, out_ready
  );
endinterface

// File: rtl/psum_addr_gen.sv
// Incremental PMEM address generator: output-pixel and kernel-index counters
// kept as row/column pairs with running offsets, so no multiply or divide.
module psum_addr_gen
  import psum_acc_reader_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  o_clr,
  input  logic  o_step,
  input  logic  j_clr,
  input  logic  j_step,
  output addr_t addr,
  output logic  o_last
);

  pix_t  o_cnt_reg, o_cnt_next;
  pix_t  o_col_reg, o_col_next;
  addr_t o_base_reg, o_base_next;
  pix_t  j_col_reg, j_col_next;
  addr_t j_off_reg, j_off_next;

  always_comb begin
    o_cnt_next  = o_cnt_reg;
    o_col_next  = o_col_reg;
    o_base_next = o_base_reg;
    if (o_clr) begin
      o_cnt_next  = '0;
      o_col_next  = '0;
      o_base_next = '0;
    end else if (o_step) begin
      o_cnt_next = o_cnt_reg + pix_t'(1);
      if (o_col_reg == O_COL_LAST) begin
        o_col_next  = '0;
        o_base_next = o_base_reg + O_ROW_STEP;
      end else begin
        o_col_next  = o_col_reg + pix_t'(1);
        o_base_next = o_base_reg + O_COL_STEP;
      end
    end
  end

  // j_off tracks (j/ki)*a_pad + j%ki + j*len_nij in one running sum.
  always_comb begin
    j_col_next = j_col_reg;
    j_off_next = j_off_reg;
    if (j_clr) begin
      j_col_next = '0;
      j_off_next = '0;
    end else if (j_step) begin
      if (j_col_reg == J_COL_LAST) begin
        j_col_next = '0;
        j_off_next = j_off_reg + J_ROW_STEP;
      end else begin
        j_col_next = j_col_reg + pix_t'(1);
        j_off_next = j_off_reg + J_COL_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cnt_reg  <= '0;
      o_col_reg  <= '0;
      o_base_reg <= '0;
      j_col_reg  <= '0;
      j_off_reg  <= '0;
    end else begin
      o_cnt_reg  <= o_cnt_next;
      o_col_reg  <= o_col_next;
      o_base_reg <= o_base_next;
      j_col_reg  <= j_col_next;
      j_off_reg  <= j_off_next;
    end
  end

  assign addr   = o_base_reg + j_off_reg;
  assign o_last = (o_cnt_reg == O_LAST);

endmodule

// File: rtl/psum_acc_reader.sv
// Sequencer that reads all kij partial sums per output pixel from PMEM,
// drives SFU clear/accumulate, and hands each result downstream.
module psum_acc_reader
  import psum_acc_reader_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  psum_acc_reader_if.master bus
);

  state_t  state_reg, state_next;
  rd_cnt_t rd_cnt_reg, rd_cnt_next;

  logic  o_last, o_clr, o_step, j_clr, j_step, issue;
  addr_t gen_addr;

  logic  busy_reg, busy_next;
  logic  done_reg, done_next;
  logic  pmem_cen_reg, pmem_cen_next;
  addr_t pmem_addr_reg, pmem_addr_next;
  logic  sfu_clr_reg, sfu_clr_next;
  logic  acc_reg, acc_next;
  logic  out_valid_reg, out_valid_next;
  vec_t  out_data_reg, out_data_next;

  psum_addr_gen u_addr_gen (
    .clk    (clk),
    .reset  (reset),
    .o_clr  (o_clr),
    .o_step (o_step),
    .j_clr  (j_clr),
    .j_step (j_step),
    .addr   (gen_addr),
    .o_last (o_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      rd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rd_cnt_reg <= rd_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rd_cnt_next = '0;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_CLR;
      ST_CLR:    state_next = ST_RD;
      ST_RD: begin
        if (rd_cnt_reg == RD_LAST) begin
          state_next = ST_SETTLE;
        end else begin
          rd_cnt_next = rd_cnt_reg + rd_cnt_t'(1);
        end
      end
      ST_SETTLE: state_next = ST_OUT;
      ST_OUT:    if (bus.out_ready) state_next = o_last ? ST_DONE : ST_CLR;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step
  // with it; the last RD slot (rd_cnt == RD_LAST) only drains the SFU.
  always_comb begin
    issue          = (state_next == ST_RD) && (rd_cnt_next != RD_LAST);
    busy_next      = (state_next != ST_IDLE) && (state_next != ST_DONE);
    done_next      = (state_next == ST_DONE);
    sfu_clr_next   = (state_next == ST_CLR);
    acc_next       = (state_next == ST_RD) && (rd_cnt_next != '0);
    pmem_cen_next  = issue ? CEN_ON : CEN_OFF;
    pmem_addr_next = issue ? gen_addr : pmem_addr_reg;
    out_valid_next = (state_next == ST_OUT);
    out_data_next  = (state_reg == ST_SETTLE) ? bus.sfu_out : out_data_reg;
    o_clr          = (state_reg == ST_IDLE) && start;
    o_step         = (state_reg == ST_OUT) && bus.out_ready && !o_last;
    j_clr          = (state_next == ST_CLR);
    j_step         = issue;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pmem_cen_reg  <= CEN_OFF;
      pmem_addr_reg <= '0;
      sfu_clr_reg   <= 1'b0;
      acc_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      pmem_cen_reg  <= pmem_cen_next;
      pmem_addr_reg <= pmem_addr_next;
      sfu_clr_reg   <= sfu_clr_next;
      acc_reg       <= acc_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign bus.pmem_cen  = pmem_cen_reg;
  assign bus.pmem_wen  = WEN_READ;
  assign bus.pmem_addr = pmem_addr_reg;
  assign bus.sfu_clr   = sfu_clr_reg;
  assign bus.acc       = acc_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_psum_acc_reader.sv
// Directed bench for psum_acc_reader with a behavioural PMEM (addr-valued
// psums) and SFU; expected vectors and addresses are hand-computed.
module tb_psum_acc_reader;
  import psum_acc_reader_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  vec_t rdata_q = '0;
  vec_t sfu_q   = '0;
  int   n_total = 0;
  int   n_bad   = 0;

  psum_acc_reader_if bus ();

  psum_acc_reader dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.sfu_out = sfu_q;

  // PMEM word at address a: lane k holds a + 64*k.
  function automatic vec_t pmem_word(input addr_t a);
    vec_t v;
    for (int k = 0; k < COL; k++) v[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(a) + PSUM_BW'(64 * k);
    return v;
  endfunction

  function automatic vec_t lane_add(input vec_t x, input vec_t y);
    vec_t v;
    for (int k = 0; k < COL; k++) v[k*PSUM_BW +: PSUM_BW] = x[k*PSUM_BW +: PSUM_BW] + y[k*PSUM_BW +: PSUM_BW];
    return v;
  endfunction

  // Sum over the 9 kernel taps: 9*base + (54 + 9 + 1296) = 9*base + 1359, plus 9*64*k per lane.
  function automatic vec_t golden(input int p);
    vec_t v;
    int base;
    base = (p / 4) * 6 + (p % 4);
    for (int k = 0; k < COL; k++) v[k*PSUM_BW +: PSUM_BW] = PSUM_BW'(9 * base + 1359 + 576 * k);
    return v;
  endfunction

  always @(posedge clk) begin
    if (bus.pmem_cen == 1'b0) rdata_q <= pmem_word(bus.pmem_addr);
    if (bus.sfu_clr) sfu_q <= '0;
    else if (bus.acc) sfu_q <= lane_add(sfu_q, rdata_q);
  end

  task automatic check_val(input string tag, input logic [VEC_BW-1:0] got, input logic [VEC_BW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_cen"}, bus.pmem_cen, 1);
    check_val({tag, "_wen"}, bus.pmem_wen, 1);
    check_val({tag, "_addr"}, bus.pmem_addr, 0);
    check_val({tag, "_clr"}, bus.sfu_clr, 0);
    check_val({tag, "_acc"}, bus.acc, 0);
    check_val({tag, "_valid"}, bus.out_valid, 0);
    check_val({tag, "_data"}, bus.out_data, 0);
  endtask

  // Runs one pass from a negedge. stall_pix: pixel whose output is held off
  // for 20 cycles; dup_cyc: cycle of a stray start pulse; abort_pix: pixel
  // on which reset is pulsed mid-RD; trace0: check pixel-0 cycle trace.
  task automatic run_pass(input int stall_pix, input int dup_cyc, input int abort_pix, input bit trace0);
    int  exp0[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};
    int  first_a[16];
    int  last_a[16];
    int  pix = 0, n_rd = 0, stall_n = 0, done_cyc = 0, exp_lat;
    bit  done_seen = 0, released = 0;
    exp_lat = (stall_pix >= 0) ? 227 : 208;
    start = 1'b1;
    for (int cyc = 1; cyc <= 400 && !done_seen; cyc++) begin
      @(negedge clk);
      start = (cyc == dup_cyc);
      if (released) begin
        check_val("clr_after_release", bus.sfu_clr, 1);
        released = 0;
      end
      if (trace0 && cyc <= 13) begin
        check_val($sformatf("p0_cen_c%0d", cyc), bus.pmem_cen, (cyc >= 2 && cyc <= 10) ? 0 : 1);
        check_val($sformatf("p0_acc_c%0d", cyc), bus.acc, (cyc >= 3 && cyc <= 11) ? 1 : 0);
        check_val($sformatf("p0_clr_c%0d", cyc), bus.sfu_clr, (cyc == 1) ? 1 : 0);
        if (cyc >= 2 && cyc <= 10) check_val($sformatf("p0_addr_c%0d", cyc), bus.pmem_addr, exp0[cyc-2]);
      end
      if (bus.pmem_cen == 1'b0 && pix < 16) begin
        if (n_rd == 0) first_a[pix] = int'(bus.pmem_addr);
        last_a[pix] = int'(bus.pmem_addr);
        n_rd++;
      end
      if (pix == abort_pix && n_rd == 4) begin
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        $display("abort pix=%0d at cyc=%0d", pix, cyc);
        return;
      end
      if (pix == stall_pix && bus.sfu_clr) bus.out_ready = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        stall_n++;
        check_val($sformatf("stall_data_%0d", stall_n), bus.out_data, golden(pix));
        check_val($sformatf("stall_cen_%0d", stall_n), bus.pmem_cen, 1);
        if (stall_n == 20) begin
          bus.out_ready = 1'b1;
          released = 1;
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        check_val("busy_at_done", busy, 0);
      end else begin
        check_val($sformatf("busy_c%0d", cyc), busy, 1);
      end
      if (bus.out_valid && bus.out_ready) begin
        check_val($sformatf("beat_%0d", pix), bus.out_data, golden(pix));
        $display("beat pix=%0d data=%h", pix, bus.out_data);
        pix++;
        n_rd = 0;
      end
    end
    check_val("done_seen", done_seen, 1);
    check_val("done_latency", done_cyc - 1, exp_lat);
    check_val("beat_count", pix, 16);
    $display("pass done latency=%0d beats=%0d", done_cyc - 1, pix);
    if (pix == 16) begin
      check_val("p5_first", first_a[5], 7);
      check_val("p5_last", last_a[5], 309);
      check_val("p15_first", first_a[15], 21);
      check_val("p15_last", last_a[15], 323);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("post_done_%0d", i), done, 0);
      check_val($sformatf("post_busy_%0d", i), busy, 0);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    run_pass(-1, -1, -1, 1'b1);
    run_pass(3, -1, -1, 1'b0);
    run_pass(-1, -1, 7, 1'b0);
    check_reset_outputs("after_abort");
    run_pass(-1, -1, -1, 1'b1);
    run_pass(-1, 50, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
